// File: rtl/lzx_194_seq_ctrl.sv
// Command sequencer for a single lzx_74HC194 universal shift register: accepts one
// load/shift/rotate/clear command at a time and drives MR, S, D, DSR and DSL to execute it.
module lzx_194_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    output logic             reg_mr_n,
    output logic [1:0]       reg_s,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_dsr,
    output logic             reg_dsl,
    input  logic [WIDTH-1:0] reg_q,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;

    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHR  = 2'b01;
    localparam logic [1:0] S_SHL  = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mr_n_q, mr_n_d;
    logic [1:0]       s_q, s_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             dsr_q, dsr_d;
    logic             dsl_q, dsl_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             in_exec;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        mr_n_d   = mr_n_q;
        s_d      = s_q;
        d_d      = d_q;
        dsr_d    = dsr_q;
        dsl_d    = dsl_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = cmd_op;
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d = ST_EXEC;
                            count_d = CNT_W'(1);
                            s_d     = S_LOAD;
                            d_d     = cmd_data;
                        end
                        OP_CLR: begin
                            state_d = ST_EXEC;
                            count_d = CNT_W'(1);
                            mr_n_d  = 1'b0;
                            s_d     = S_HOLD;
                        end
                        OP_SHR, OP_ROR: begin
                            if (cmd_cnt == '0) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_EXEC;
                                count_d = cmd_cnt;
                                s_d     = S_SHR;
                                // Rotates take DSR straight from reg_q instead.
                                dsr_d   = (cmd_op == OP_SHR) & cmd_fill;
                            end
                        end
                        OP_SHL, OP_ROL: begin
                            if (cmd_cnt == '0) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_EXEC;
                                count_d = cmd_cnt;
                                s_d     = S_SHL;
                                dsl_d   = (cmd_op == OP_SHL) & cmd_fill;
                            end
                        end
                        default: begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    // Return the register to hold before DONE so Q cannot move again.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    count_d = '0;
                    mr_n_d  = 1'b1;
                    s_d     = S_HOLD;
                    d_d     = '0;
                    dsr_d   = 1'b0;
                    dsl_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                result_d = reg_q;
            end
            default: begin
                state_d = ST_IDLE;
                mr_n_d  = 1'b1;
                s_d     = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b000;
            count_q  <= '0;
            mr_n_q   <= 1'b1;
            s_q      <= S_HOLD;
            d_q      <= '0;
            dsr_q    <= 1'b0;
            dsl_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            mr_n_q   <= mr_n_d;
            s_q      <= s_d;
            d_q      <= d_d;
            dsr_q    <= dsr_d;
            dsl_q    <= dsl_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign in_exec   = (state_q == ST_EXEC);
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign reg_mr_n  = mr_n_q;
    assign reg_s     = s_q;
    assign reg_d     = d_q;
    assign reg_dsr   = (in_exec && op_q == OP_ROR) ? reg_q[WIDTH-1] : dsr_q;
    assign reg_dsl   = (in_exec && op_q == OP_ROL) ? reg_q[0] : dsl_q;

endmodule

// File: tb/tb_lzx_194_seq_ctrl.sv
// Bench for lzx_194_seq_ctrl: a behavioural 74HC194 closes the loop, and each command is
// checked against a command-level model of the final value, latency and S activity.
module tb_lzx_194_seq_ctrl;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    logic       CLK = 1'b0;
    logic       MR;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_cnt;
    logic       cmd_fill;
    logic       reg_mr_n;
    logic [1:0] reg_s;
    logic [3:0] reg_d;
    logic       reg_dsr;
    logic       reg_dsl;
    logic [3:0] q194 = 4'h0;
    logic       busy;
    logic       done;
    logic [3:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] q_exp = 4'h0;

    lzx_194_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
        .CLK       (CLK),
        .MR        (MR),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .cmd_fill  (cmd_fill),
        .reg_mr_n  (reg_mr_n),
        .reg_s     (reg_s),
        .reg_d     (reg_d),
        .reg_dsr   (reg_dsr),
        .reg_dsl   (reg_dsl),
        .reg_q     (q194),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 CLK = ~CLK;

    // Behavioural 74HC194 datapath.
    always @(posedge CLK or negedge reg_mr_n) begin
        if (!reg_mr_n) q194 <= 4'h0;
        else begin
            case (reg_s)
                2'b01:   q194 <= {q194[2:0], reg_dsr};
                2'b10:   q194 <= {reg_dsl, q194[3:1]};
                2'b11:   q194 <= reg_d;
                default: q194 <= q194;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic bit is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

    // Register contents after n single steps of a shift/rotate op.
    function automatic logic [3:0] step_n(input logic [2:0] op, input logic [3:0] v, input int n,
                                          input logic fill);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < n; i++) begin
            case (op)
                OP_SHR:  r = {r[2:0], fill};
                OP_SHL:  r = {fill, r[3:1]};
                OP_ROR:  r = {r[2:0], r[3]};
                OP_ROL:  r = {r[0], r[3:1]};
                default: r = r;
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] apply_cmd(input logic [2:0] op, input logic [3:0] data,
                                             input logic [3:0] cnt, input logic fill,
                                             input logic [3:0] v);
        if (op == OP_LOAD) return data;
        if (op == OP_CLR) return 4'h0;
        if (is_shift(op)) return step_n(op, v, int'(cnt), fill);
        return v;
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [3:0] cnt);
        if (op == OP_LOAD || op == OP_CLR) return 2;
        if (is_shift(op)) return 1 + int'(cnt);
        return 1;
    endfunction

    function automatic int exp_active(input logic [2:0] op, input logic [3:0] cnt);
        if (op == OP_LOAD) return 1;
        if (is_shift(op)) return int'(cnt);
        return 0;
    endfunction

    function automatic logic [1:0] exp_scode(input logic [2:0] op);
        if (op == OP_LOAD) return 2'b11;
        if (op == OP_SHR || op == OP_ROR) return 2'b01;
        if (op == OP_SHL || op == OP_ROL) return 2'b10;
        return 2'b00;
    endfunction

    // Issue one command; returns on the IDLE cycle after done. With hold set, cmd_valid
    // stays high carrying junk while busy, and the caller must present the next command.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input logic [3:0] cnt,
                           input logic fill, input logic hold);
        int         wait_n;
        int         lat;
        int         act;
        int         bad;
        int         clr;
        bit         seen;
        logic [3:0] start;
        logic [3:0] fin;
        logic [1:0] scode;
        start  = q_exp;
        fin    = apply_cmd(op, data, cnt, fill, start);
        scode  = exp_scode(op);
        wait_n = 0;
        lat    = 0;
        act    = 0;
        bad    = 0;
        clr    = 0;
        seen   = 1'b0;
        while (!cmd_ready && wait_n < 50) begin
            @(negedge CLK);
            wait_n++;
        end
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        cmd_fill  = fill;
        @(posedge CLK);
        #1;
        cmd_valid = hold;
        for (int i = 0; i < 40; i++) begin
            cmd_op   = 3'($urandom);
            cmd_data = 4'($urandom);
            cmd_cnt  = 4'($urandom);
            cmd_fill = 1'($urandom);
            @(negedge CLK);
            if (reg_s != 2'b00) begin
                if (reg_s == scode) act++;
                else bad++;
                if (reg_s == 2'b11 && reg_d !== data) bad++;
            end
            if (!reg_mr_n) clr++;
            if (is_shift(op) && i <= int'(cnt))
                check("q_step", 32'(q194), 32'(step_n(op, start, i, fill)));
            if (done) begin
                lat  = i + 1;
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(lat), 32'(exp_latency(op, cnt)));
            check("s_active_cycles", 32'(act), 32'(exp_active(op, cnt)));
            check("s_wrong_code", 32'(bad), 32'd0);
            check("mr_low_cycles", 32'(clr), (op == OP_CLR) ? 32'd1 : 32'd0);
            check("q_at_done", 32'(q194), 32'(fin));
            check("busy_at_done", 32'(busy), 32'd1);
            check("ready_at_done", 32'(cmd_ready), 32'd0);
            @(negedge CLK);
            check("done_pulse_width", 32'(done), 32'd0);
            check("result", 32'(result), 32'(fin));
            check("ready_after_done", 32'(cmd_ready), 32'd1);
            check("s_hold_idle", 32'(reg_s), 32'd0);
        end
        q_exp = fin;
    endtask

    initial begin
        bit         saw_done;
        logic [2:0] r_op;
        logic [3:0] r_cnt;
        MR        = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 4'h0;
        cmd_cnt   = 4'h0;
        cmd_fill  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s", 32'(reg_s), 32'd0);
        check("rst_mr_n", 32'(reg_mr_n), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dsr_dsl", 32'({reg_dsr, reg_dsl, reg_d}), 32'd0);
        MR = 1'b1;
        @(negedge CLK);

        run_cmd(OP_LOAD, 4'hA, 4'd0, 1'b0, 1'b0);
        run_cmd(OP_ROR, 4'h0, 4'd5, 1'b0, 1'b0);
        check("ror_result_5", 32'(result), 32'h5);
        run_cmd(OP_SHL, 4'h0, 4'd2, 1'b1, 1'b0);
        check("shl_result_d", 32'(result), 32'hD);
        run_cmd(OP_SHR, 4'h0, 4'd0, 1'b1, 1'b0);
        run_cmd(OP_CLR, 4'h0, 4'd0, 1'b0, 1'b1);
        run_cmd(OP_LOAD, 4'h3, 4'd0, 1'b0, 1'b0);
        run_cmd(OP_RSV, 4'hF, 4'd9, 1'b1, 1'b0);
        run_cmd(OP_NOP, 4'hF, 4'd9, 1'b1, 1'b0);
        run_cmd(OP_ROL, 4'h0, 4'd15, 1'b0, 1'b0);

        // Reset in the middle of a 7-step ROL.
        cmd_valid = 1'b1;
        cmd_op    = OP_ROL;
        cmd_cnt   = 4'd7;
        cmd_fill  = 1'b0;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);
        MR = 1'b0;
        #1;
        check("midrst_s", 32'(reg_s), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_mr_n", 32'(reg_mr_n), 32'd1);
        check("midrst_q_two_steps", 32'(q194), 32'(step_n(OP_ROL, q_exp, 2, 1'b0)));
        q_exp = step_n(OP_ROL, q_exp, 2, 1'b0);
        @(negedge CLK);
        MR = 1'b1;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);
        run_cmd(OP_SHR, 4'h0, 4'd3, 1'b1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_cnt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 4));
            run_cmd(r_op, 4'($urandom), r_cnt, 1'($urandom), 1'($urandom));
        end
        cmd_valid = 1'b0;
        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
